// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick countdown timer.
//   state_t   : timer FSM states (IDLE, RUN, PAUSED, DONE)
//   RATE_*    : rate_sel_i encodings for the tick source mux
package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [1:0] RATE_1HZ  = 2'b00;
  localparam logic [1:0] RATE_5HZ  = 2'b01;
  localparam logic [1:0] RATE_10HZ = 2'b10;
  localparam logic [1:0] RATE_FAST = 2'b11;

endpackage

// File: rtl/level_edge_tick.sv
// Converts a divided-clock level into a single-cycle tick in the clock_i
// domain. The tick is high for one cycle when the sampled level is 1 and the
// previous sample was 0. Runs continuously, independent of any timer state.
//
// Optional build macro TICK_SYNC_EN: when defined, the level first passes a
// 2-flop synchronizer (adds 2 cycles of latency, safe for asynchronous
// sources). When undefined, the level must already be registered in the
// clock_i domain and only one history flop is used.
//
// Ports:
//   clock_i  in  system clock
//   reset_i  in  synchronous active-high reset, clears all history
//   level_i  in  divided level
//   tick_o   out one-cycle pulse per rising edge of level_i
module level_edge_tick (
  input  logic clock_i,
  input  logic reset_i,
  input  logic level_i,
  output logic tick_o
);

`ifdef TICK_SYNC_EN
  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  // synchronizer stages, then one flop of edge history
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      sync_p0 <= level_i;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign tick_o = sync_p1 & ~hist_p2;
`else
  logic hist_p0;

  // one flop of edge history on the already-registered level
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hist_p0 <= 1'b0;
    end else begin
      hist_p0 <= level_i;
    end
  end

  assign tick_o = level_i & ~hist_p0;
`endif

endmodule

// File: rtl/tick_countdown_timer.sv
// Loadable countdown timer driven by tick enables derived from the divider's
// 1 Hz / 5 Hz / 10 Hz levels (or every cycle in test rate). Replaces any use
// of divided clocks as flop clocks.
//
// Optional build macro TICK_SYNC_EN: synchronize each divided level with two
// flops before edge detection (see level_edge_tick).
//
// Ports:
//   clock_i       in  system clock, all logic on posedge
//   reset_i       in  synchronous active-high reset
//   clock_1Hz_i   in  1 Hz level
//   clock_5Hz_i   in  5 Hz level
//   clock_10Hz_i  in  10 Hz level
//   rate_sel_i    in  tick source (RATE_1HZ/5HZ/10HZ/FAST)
//   load_i        in  load load_value_i, go to IDLE
//   load_value_i  in  value to load
//   start_i       in  start / resume
//   pause_i       in  pause (only in RUN)
//   count_o       out current count
//   running_o     out high in RUN
//   done_o        out high in DONE
//   expired_o     out one-cycle pulse on entry to DONE
//   tick_o        out selected tick, free-running
module tick_countdown_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clock_1Hz_i,
  input  logic             clock_5Hz_i,
  input  logic             clock_10Hz_i,
  input  logic [1:0]       rate_sel_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             start_i,
  input  logic             pause_i,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             done_o,
  output logic             expired_o,
  output logic             tick_o
);

  logic   tick_1hz;
  logic   tick_5hz;
  logic   tick_10hz;
  logic   sel_tick;
  state_t state;

  level_edge_tick u_edge_1hz (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .level_i (clock_1Hz_i),
    .tick_o  (tick_1hz)
  );

  level_edge_tick u_edge_5hz (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .level_i (clock_5Hz_i),
    .tick_o  (tick_5hz)
  );

  level_edge_tick u_edge_10hz (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .level_i (clock_10Hz_i),
    .tick_o  (tick_10hz)
  );

  // The mux only selects among detectors that run all the time, so switching
  // rate cannot fabricate an edge; the new source ticks on its own next edge.
  always_comb begin
    sel_tick = 1'b0;
    case (rate_sel_i)
      RATE_1HZ:  sel_tick = tick_1hz;
      RATE_5HZ:  sel_tick = tick_5hz;
      RATE_10HZ: sel_tick = tick_10hz;
      RATE_FAST: sel_tick = 1'b1;
      default:   sel_tick = 1'b0;
    endcase
  end

  // tick_o must lead the count update by one cycle, so it is the live mux
  // output; it is forced low while reset is asserted.
  assign tick_o = sel_tick & ~reset_i;

  // FSM and counter; every status output is a flop updated with the state
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state     <= IDLE;
      count_o   <= '0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
      expired_o <= 1'b0;
    end else begin
      expired_o <= 1'b0;
      if (load_i) begin
        state     <= IDLE;
        count_o   <= load_value_i;
        running_o <= 1'b0;
        done_o    <= 1'b0;
      end else begin
        case (state)
          IDLE, PAUSED: begin
            if (start_i) begin
              if (count_o != '0) begin
                state     <= RUN;
                running_o <= 1'b1;
              end else begin
                state     <= DONE;
                done_o    <= 1'b1;
                expired_o <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pause_i) begin
              // a coincident tick is dropped
              state     <= PAUSED;
              running_o <= 1'b0;
            end else if (sel_tick && count_o != '0) begin
              count_o <= count_o - WIDTH'(1);
              if (count_o == WIDTH'(1)) begin
                state     <= DONE;
                running_o <= 1'b0;
                done_o    <= 1'b1;
                expired_o <= 1'b1;
              end
            end
          end
          DONE: begin
            // only load or reset leave DONE
          end
          default: begin
            state     <= IDLE;
            running_o <= 1'b0;
            done_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_countdown_timer.sv
module tb_tick_countdown_timer;

`ifdef TICK_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       clock_1Hz_i, clock_5Hz_i, clock_10Hz_i;
  logic [1:0] rate_sel_i;
  logic       load_i;
  logic [7:0] load_value_i;
  logic       start_i;
  logic       pause_i;
  logic [7:0] count_o;
  logic       running_o, done_o, expired_o, tick_o;

  int total = 0;
  int bad   = 0;

  tick_countdown_timer #(.WIDTH(8)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .clock_1Hz_i  (clock_1Hz_i),
    .clock_5Hz_i  (clock_5Hz_i),
    .clock_10Hz_i (clock_10Hz_i),
    .rate_sel_i   (rate_sel_i),
    .load_i       (load_i),
    .load_value_i (load_value_i),
    .start_i      (start_i),
    .pause_i      (pause_i),
    .count_o      (count_o),
    .running_o    (running_o),
    .done_o       (done_o),
    .expired_o    (expired_o),
    .tick_o       (tick_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, 1 run, 2 paused, 3 done
  int   m_mode, m_cnt, m_exp;
  bit   m_valid = 0;
  logic hist [0:2][0:3];   // hist[s][k] = level of source s sampled k+1 edges ago

  function automatic logic lvl(input int s);
    return (s == 0) ? clock_1Hz_i : (s == 1) ? clock_5Hz_i : clock_10Hz_i;
  endfunction

  // A source ticks when its level, seen D cycles late, has just gone 0 -> 1.
  function automatic logic src_tick(input int s);
    logic seq [0:4];
    seq[0] = lvl(s);
    for (int k = 1; k <= 4; k++) seq[k] = hist[s][k-1];
    return seq[D] & ~seq[D+1];
  endfunction

  function automatic logic m_tick();
    if (reset_i) return 1'b0;
    if (rate_sel_i == 2'b11) return 1'b1;
    return src_tick(int'(rate_sel_i));
  endfunction

  always @(posedge clock_i) begin
    logic tk;
    if (reset_i) begin
      m_valid = 1;
      m_mode  = 0;
      m_cnt   = 0;
      m_exp   = 0;
      for (int s = 0; s < 3; s++)
        for (int k = 0; k < 4; k++) hist[s][k] = 1'b0;
    end else if (m_valid) begin
      tk    = m_tick();
      m_exp = 0;
      if (load_i) begin
        m_cnt  = int'(load_value_i);
        m_mode = 0;
      end else if (m_mode == 1 && pause_i) begin
        m_mode = 2;
      end else if ((m_mode == 0 || m_mode == 2) && start_i) begin
        if (m_cnt != 0) m_mode = 1;
        else begin m_mode = 3; m_exp = 1; end
      end else if (m_mode == 1 && tk && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_mode = 3; m_exp = 1; end
      end
      for (int s = 0; s < 3; s++) begin
        for (int k = 3; k > 0; k--) hist[s][k] = hist[s][k-1];
        hist[s][0] = lvl(s);
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clock_i) begin
    if (m_valid) begin
      chk("mdl_count",   int'(count_o),   m_cnt);
      chk("mdl_running", int'(running_o), int'(m_mode == 1));
      chk("mdl_done",    int'(done_o),    int'(m_mode == 3));
      chk("mdl_expired", int'(expired_o), m_exp);
      chk("mdl_tick",    int'(tick_o),    int'(m_tick()));
    end
  end

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    int seq5 [5] = '{4, 3, 2, 1, 0};
    logic [1:0] rates [3] = '{2'b01, 2'b10, 2'b00};
    reset_i = 1; clock_1Hz_i = 0; clock_5Hz_i = 0; clock_10Hz_i = 0;
    rate_sel_i = 2'b00; load_i = 0; load_value_i = 0; start_i = 0; pause_i = 0;
    cyc(); cyc();
    reset_i = 0;
    cyc();
    chk("rst_count", count_o, 0);
    chk("rst_running", running_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_expired", expired_o, 0);
    chk("rst_tick", tick_o, 0);

    // start with count 0 -> DONE immediately
    start_i = 1; cyc();
    chk("zero_done", done_o, 1);
    chk("zero_expired", expired_o, 1);
    start_i = 0; cyc();
    chk("zero_expired_once", expired_o, 0);
    chk("zero_done_hold", done_o, 1);

    // fast rate countdown 5..0
    rate_sel_i = 2'b11; load_i = 1; load_value_i = 8'd5; cyc();
    load_i = 0; start_i = 1; cyc();
    chk("fast_start_count", count_o, 5);
    chk("fast_running", running_o, 1);
    start_i = 0;
    foreach (seq5[i]) begin
      cyc();
      chk("fast_seq", count_o, seq5[i]);
      chk("fast_exp", expired_o, int'(seq5[i] == 0));
    end
    start_i = 1; cyc();
    chk("fast_done_hold", done_o, 1);
    chk("fast_start_ignored", count_o, 0);
    chk("fast_exp_once", expired_o, 0);
    start_i = 0;

    // 1 Hz rate: one decrement per rising level edge, at latency D+1
    rate_sel_i = 2'b00; load_i = 1; load_value_i = 8'd3; cyc();
    load_i = 0; start_i = 1; cyc();
    start_i = 0;
    clock_1Hz_i = 1;
    repeat (D) begin cyc(); chk("slow_wait", count_o, 3); end
    #1 chk("slow_tick", tick_o, 1);
    cyc();
    chk("slow_dec1", count_o, 2);
    repeat (4) cyc();
    clock_1Hz_i = 0;
    repeat (6) cyc();
    chk("slow_fall_nodec", count_o, 2);
    clock_1Hz_i = 1;
    repeat (D + 1) cyc();
    chk("slow_dec2", count_o, 1);
    clock_1Hz_i = 0;
    repeat (4) cyc();

    // pause coinciding with a tick drops the tick
    rate_sel_i = 2'b11; load_i = 1; load_value_i = 8'd9; cyc();
    load_i = 0; start_i = 1; cyc();
    start_i = 0; pause_i = 1; cyc();
    chk("pause_count", count_o, 9);
    chk("pause_running", running_o, 0);
    pause_i = 0; start_i = 1; cyc();
    chk("resume_running", running_o, 1);
    start_i = 0; cyc();
    chk("resume_dec", count_o, 8);

    // load beats start
    load_i = 1; start_i = 1; load_value_i = 8'd9; cyc();
    chk("ldst_count", count_o, 9);
    chk("ldst_running", running_o, 0);
    load_i = 0; start_i = 0;

    // reset mid-RUN
    rate_sel_i = 2'b00; load_i = 1; load_value_i = 8'd4; cyc();
    load_i = 0; start_i = 1; cyc();
    start_i = 0; cyc();
    chk("mid_count", count_o, 4);
    reset_i = 1; cyc();
    chk("midrst_count", count_o, 0);
    chk("midrst_running", running_o, 0);
    chk("midrst_expired", expired_o, 0);
    reset_i = 0; cyc();
    chk("midrst_expired2", expired_o, 0);

    // rate switching with static-high levels never ticks
    clock_1Hz_i = 1; clock_5Hz_i = 1; clock_10Hz_i = 1;
    repeat (6) cyc();
    foreach (rates[i]) begin
      rate_sel_i = rates[i];
      #1 chk("ratesw_tick", tick_o, 0);
      cyc();
    end
    clock_1Hz_i = 0; clock_5Hz_i = 0; clock_10Hz_i = 0;

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset_i      = ($urandom_range(0, 199) == 0);
      load_i       = ($urandom_range(0, 29) == 0);
      load_value_i = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      start_i      = ($urandom_range(0, 7) == 0);
      pause_i      = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 39) == 0) rate_sel_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) clock_1Hz_i  = ~clock_1Hz_i;
      if ($urandom_range(0, 5)  == 0) clock_5Hz_i  = ~clock_5Hz_i;
      if ($urandom_range(0, 2)  == 0) clock_10Hz_i = ~clock_10Hz_i;
    end
    reset_i = 0; load_i = 0; start_i = 0; pause_i = 0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
